// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit registered ALU: operand width and opcode encodings.
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Arithmetic and shift ops produce a meaningful carry and update the sticky flag.
    function automatic logic is_carry_op(input logic [2:0] op_sel);
        return (op_sel == OP_ADD) || (op_sel == OP_SUB) ||
               (op_sel == OP_SHL) || (op_sel == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_adder8.sv
// Combinational ripple-carry adder for the ALU datapath; SUB reuses it with an inverted b.
module alu_adder8
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             cin,
    output logic [ALU_W-1:0] sum,
    output logic             cout
);

    logic [ALU_W:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < ALU_W; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[ALU_W];

endmodule

// File: rtl/alu_8bit.sv
// 8-bit registered ALU with carry-out, sticky carry flag and zero flag (one-cycle latency).
// Define ALU_ROTATE_EN to turn SHL/SHR into rotates (fill from the outgoing bit, cin ignored).
module alu_8bit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  logic [2:0]       op,
    input  logic             cin,
    output logic [ALU_W-1:0] out,
    output logic             cout,
    output logic             c_flag,
    output logic             zero
);

    logic [ALU_W-1:0] add_b;
    logic [ALU_W-1:0] add_sum;
    logic             add_cout;
    logic             shl_fill;
    logic             shr_fill;

    logic [ALU_W-1:0] out_reg,    out_next;
    logic             cout_reg,   cout_next;
    logic             c_flag_reg, c_flag_next;
    logic             zero_reg,   zero_next;

    assign add_b = (op == OP_SUB) ? ~B : B;

    alu_adder8 u_adder (
        .a    (A),
        .b    (add_b),
        .cin  (cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef ALU_ROTATE_EN
    assign shl_fill = A[ALU_W-1];
    assign shr_fill = A[0];
`else
    assign shl_fill = cin;
    assign shr_fill = cin;
`endif

    always_comb begin
        out_next  = '0;
        cout_next = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                out_next  = add_sum;
                cout_next = add_cout;
            end
            OP_AND: out_next = A & B;
            OP_OR:  out_next = A | B;
            OP_XOR: out_next = A ^ B;
            OP_NOT: out_next = ~A;
            OP_SHL: begin
                out_next  = {A[ALU_W-2:0], shl_fill};
                cout_next = A[ALU_W-1];
            end
            OP_SHR: begin
                out_next  = {shr_fill, A[ALU_W-1:1]};
                cout_next = A[0];
            end
            default: begin
                out_next  = '0;
                cout_next = 1'b0;
            end
        endcase
        c_flag_next = is_carry_op(op) ? cout_next : c_flag_reg;
        zero_next   = (out_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg    <= '0;
            cout_reg   <= 1'b0;
            c_flag_reg <= 1'b0;
            zero_reg   <= 1'b1;
        end else begin
            out_reg    <= out_next;
            cout_reg   <= cout_next;
            c_flag_reg <= c_flag_next;
            zero_reg   <= zero_next;
        end
    end

    assign out    = out_reg;
    assign cout   = cout_reg;
    assign c_flag = c_flag_reg;
    assign zero   = zero_reg;

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: arithmetic reference model plus directed literal checks.
module tb_alu_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] a_s;
    logic [7:0] b_s;
    logic [2:0] op_s;
    logic       cin_s;
    logic [7:0] out;
    logic       cout;
    logic       c_flag;
    logic       zero;

    int checks = 0;
    int errors = 0;

    alu_8bit dut (
        .clk    (clk),
        .rst    (rst),
        .A      (a_s),
        .B      (b_s),
        .op     (op_s),
        .cin    (cin_s),
        .out    (out),
        .cout   (cout),
        .c_flag (c_flag),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic returning {cout, out}.
    function automatic logic [8:0] model_res(input int a, input int b, input int o, input int c);
        int s;
        int fill;
        s = 0;
        case (o)
            0: s = a + b + c;
            1: s = a + (255 - b) + c;
            2: s = a & b;
            3: s = a | b;
            4: s = a ^ b;
            5: s = 255 - a;
            6: begin
`ifdef ALU_ROTATE_EN
                fill = a / 128;
`else
                fill = c;
`endif
                s = (a % 128) * 2 + fill + (a / 128) * 256;
            end
            default: begin
`ifdef ALU_ROTATE_EN
                fill = a % 2;
`else
                fill = c;
`endif
                s = a / 2 + fill * 128 + (a % 2) * 256;
            end
        endcase
        return s[8:0];
    endfunction

    logic [8:0] m_next;
    logic [7:0] m_out   = 8'h00;
    logic       m_cout  = 1'b0;
    logic       m_c     = 1'b0;
    logic       m_valid = 1'b0;

    always_comb m_next = model_res(int'(a_s), int'(b_s), int'(op_s), int'(cin_s));

    always @(posedge clk) begin
        m_valid <= 1'b1;
        if (rst) begin
            m_out  <= 8'h00;
            m_cout <= 1'b0;
            m_c    <= 1'b0;
        end else begin
            m_out  <= m_next[7:0];
            m_cout <= m_next[8];
            if (op_s == 3'd0 || op_s == 3'd1 || op_s >= 3'd6)
                m_c <= m_next[8];
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (out !== m_out || cout !== m_cout || c_flag !== m_c || zero !== (m_out == 8'h00)) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got out=%h cout=%b c_flag=%b zero=%b expected out=%h cout=%b c_flag=%b zero=%b",
                         $time, out, cout, c_flag, zero, m_out, m_cout, m_c, (m_out == 8'h00));
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o, input logic c);
        a_s   = a;
        b_s   = b;
        op_s  = o;
        cin_s = c;
        @(posedge clk);
        @(negedge clk);
        $display("rst=%b A=%h B=%h op=%0d cin=%b -> out=%h cout=%b c_flag=%b zero=%b",
                 rst, a, b, o, c, out, cout, c_flag, zero);
    endtask

    logic [7:0] tbl_out  [6] = '{8'h6D, 8'h51, 8'h0E, 8'h5F, 8'h51, 8'hA0};
    logic       tbl_cout [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       tbl_c    [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        rst   = 1'b1;
        a_s   = 8'h00;
        b_s   = 8'h00;
        op_s  = 3'd0;
        cin_s = 1'b0;

        // Reset for two cycles
        step(8'h12, 8'h34, 3'd0, 1'b1);
        step(8'h12, 8'h34, 3'd0, 1'b1);
        chk("rst_out", out, 8'h00);
        chk("rst_cout", {7'd0, cout}, 8'h00);
        chk("rst_cflag", {7'd0, c_flag}, 8'h00);
        chk("rst_zero", {7'd0, zero}, 8'h01);
        rst = 1'b0;

        // A=95, B=14, ops 000..101 with cin = op[0]
        for (int i = 0; i < 6; i++) begin
            logic [2:0] o;
            o = 3'(i);
            step(8'd95, 8'd14, o, o[0]);
            chk($sformatf("seq_out_op%0d", i), out, tbl_out[i]);
            chk($sformatf("seq_cout_op%0d", i), {7'd0, cout}, {7'd0, tbl_cout[i]});
            chk($sformatf("seq_cflag_op%0d", i), {7'd0, c_flag}, {7'd0, tbl_c[i]});
        end

`ifdef ALU_ROTATE_EN
        step(8'd95, 8'd14, 3'd6, 1'b0);
        chk("shl_out", out, 8'hBE);
        chk("shl_cout", {7'd0, cout}, 8'h00);
        chk("shl_cflag", {7'd0, c_flag}, 8'h00);
        step(8'd95, 8'd14, 3'd7, 1'b1);
        chk("shr_out", out, 8'hAF);
        chk("shr_cout", {7'd0, cout}, 8'h01);
        step(8'h81, 8'h00, 3'd6, 1'b0);
        chk("rol_out", out, 8'h03);
        chk("rol_cout", {7'd0, cout}, 8'h01);
        step(8'h81, 8'h00, 3'd7, 1'b0);
        chk("ror_out_cin0", out, 8'hC0);
        chk("ror_cout", {7'd0, cout}, 8'h01);
        step(8'h81, 8'h00, 3'd7, 1'b1);
        chk("ror_out_cin1", out, 8'hC0);
`else
        step(8'd95, 8'd14, 3'd6, 1'b0);
        chk("shl_out", out, 8'hBE);
        chk("shl_cout", {7'd0, cout}, 8'h00);
        chk("shl_cflag", {7'd0, c_flag}, 8'h00);
        step(8'd95, 8'd14, 3'd7, 1'b1);
        chk("shr_out", out, 8'hAF);
        chk("shr_cout", {7'd0, cout}, 8'h01);
        chk("shr_cflag", {7'd0, c_flag}, 8'h01);
        step(8'h81, 8'h00, 3'd6, 1'b0);
        chk("shl81_out", out, 8'h02);
        chk("shl81_cout", {7'd0, cout}, 8'h01);
        step(8'h81, 8'h00, 3'd7, 1'b0);
        chk("shr81_out", out, 8'h40);
        chk("shr81_cout", {7'd0, cout}, 8'h01);
`endif

        // Zero flag and wrap
        step(8'hFF, 8'h01, 3'd0, 1'b0);
        chk("wrap_add_out", out, 8'h00);
        chk("wrap_add_cout", {7'd0, cout}, 8'h01);
        chk("wrap_add_zero", {7'd0, zero}, 8'h01);
        step(8'h3C, 8'h3C, 3'd1, 1'b1);
        chk("sub_eq_out", out, 8'h00);
        chk("sub_eq_cout", {7'd0, cout}, 8'h01);
        chk("sub_eq_zero", {7'd0, zero}, 8'h01);

        // Reset in the middle of an ADD stream
        step(8'hFF, 8'hFF, 3'd0, 1'b0);
        step(8'hFF, 8'hFF, 3'd0, 1'b0);
        rst = 1'b1;
        step(8'hFF, 8'hFF, 3'd0, 1'b0);
        chk("midrst_out", out, 8'h00);
        chk("midrst_cout", {7'd0, cout}, 8'h00);
        chk("midrst_cflag", {7'd0, c_flag}, 8'h00);
        chk("midrst_zero", {7'd0, zero}, 8'h01);
        rst = 1'b0;
        step(8'hFF, 8'hFF, 3'd0, 1'b0);
        chk("post_rst_out", out, 8'hFE);
        chk("post_rst_cout", {7'd0, cout}, 8'h01);
        chk("post_rst_cflag", {7'd0, c_flag}, 8'h01);

        // Random back-to-back ops, checked by the model every cycle
        for (int i = 0; i < 40; i++) begin
            step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
